intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
- Parametrised interrupt controller replacing the fixed 2-source interrupt encoding at the core top level.
- Latches NUM_SRC sources (edge or level per source), masks them, fixed-priority encodes them to a cause code, and presents one request to the datapath CSR logic.
- Request handshake: ack when trap is taken, complete on mret.
- Sits between the timer/external pins and the datapath interrupt input.

Parameters:
NUM_SRC, 4, number of interrupt sources; must be 1..(2**CAUSE_W)-1
CAUSE_W, 4, width of cause code driven to datapath

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
src  input  NUM_SRC  raw interrupt lines; bit 0 = timer overflow, bit 1 = external
edge_mode  input  NUM_SRC  per source: 1 = rising-edge latched, 0 = level
src_en  input  NUM_SRC  per-source enable mask
global_en  input  1  global interrupt enable (mstatus.MIE)
irq_ack  input  1  datapath took the trap this cycle
irq_complete  input  1  mret retired
irq_valid  output  1  request pending to datapath
irq_cause  output  CAUSE_W  cause code; 0 = none, source i -> i+1
pending  output  NUM_SRC  raw pending vector (before mask), for CSR mip
in_service  output  1  handler active

Behaviour:
- Reset (async, rst=1): pending=0, src_q=0, state=IDLE, irq_valid=0, irq_cause=0, in_service=0.
- Edge source i: rise = src[i] & ~src_q[i]; pending[i] set on clock edge when rise=1.
- Edge source i: pending[i] cleared on the edge where irq_ack=1 in REQ and latched cause = i+1.
- Edge source i: simultaneous set and clear -> set wins (pending stays 1).
- Level source: pending[i] = registered src[i]; never latched; clears only when the source drops.
- Eligible vector = pending & src_en, gated by global_en.
- Priority: lowest index wins, so timer beats external, as in the existing 2-source encoding.
- State machine IDLE / REQ / SERVICE.
- IDLE: eligible != 0 -> REQ; cause register <= encoded winner.
- REQ:
  - irq_valid=1; irq_cause holds the latched value, stable until leaving REQ.
  - A higher-priority arrival does not change the cause (no preemption).
  - irq_ack -> SERVICE.
  - Else global_en=0 or winning source no longer eligible -> IDLE; cause <= 0; request withdrawn.
  - Same-cycle ack and withdraw: ack wins.
- SERVICE: in_service=1, irq_valid=0, irq_cause=0. irq_complete -> IDLE. No nesting.
- Re-request: a pending source re-requests no earlier than 1 cycle after return to IDLE.
- Ignored inputs: irq_ack outside REQ; irq_complete outside SERVICE.
- Latency: src rises before edge e1 -> pending=1 after e1 -> irq_valid=1 after e2 (2 cycles).
- Outputs irq_valid and in_service decode from the state register only; irq_cause comes from a register.
- Reset mid-REQ or mid-SERVICE: immediate IDLE; all pending lost.
- Elaboration: assertion fails if NUM_SRC > 2**CAUSE_W-1.

Optional Feature:
- INTR_SYNC_EN defined: each src bit passes through a 2-flop synchroniser, reset to 0, before edge detection and level sampling. Latency becomes 4 cycles; pulses shorter than 1 cycle are not guaranteed.
- Not defined: src is used directly (sources must be synchronous to clk); latency 2 cycles.

Decomposition:
- Package intr_pkg:
  - intr_state_e enum {IDLE, REQ, SERVICE}.
  - CAUSE_NONE = 0.
  - Function idx_to_cause (index+1).
- Sub-module intr_prio_enc, parametrised on NUM_SRC/CAUSE_W:
  - Combinational lowest-index-first encoder.
  - Outputs any_valid and cause.
  - Reused by future vectored-CSR work.
- All state, pending and synchroniser logic stays in intr_ctrl.

Test Plan (NUM_SRC=4, CAUSE_W=4, macro off unless stated):
1. Reset then global_en=1, src_en=4'hF, edge_mode=4'hF, 1-cycle pulse on src[1] -> pending=4'b0010 after 1 edge, irq_valid=1, irq_cause=2 after 2 edges; irq_ack -> pending=0, in_service=1; irq_complete -> IDLE, irq_valid=0.
2. src[0] and src[1] pulse the same cycle -> cause=1. After ack+complete, cause=2 is requested 1 cycle after IDLE.
3. In REQ with cause=2, src[0] rises -> cause stays 2 until ack. Drop global_en in REQ without ack -> irq_valid=0 next cycle, pending[1] still 1. Re-enable -> cause=1 requested.
4. Level source: edge_mode[2]=0, src[2] held high -> ack does not clear pending[2]. After complete, re-request cause=3 while src[2] high; lower src[2] -> pending[2]=0 one cycle later, no request.
5. Edge on src[3] in the same cycle as irq_ack of cause=4 -> pending[3] remains 1. Assert rst asynchronously mid-SERVICE -> all outputs 0 without a clock edge.
6. INTR_SYNC_EN defined: pulse on src[0] -> irq_valid=1 exactly 4 edges later, cause=1.

Source files
------------

// File: rtl/intr_pkg.sv
// ============================================================================
// Module   : intr_pkg
// Purpose  : Shared state type, cause constants and helpers for intr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

    localparam int CAUSE_NONE = 0;

    // Source index i is reported to the datapath as cause i+1; 0 means none.
    function automatic int idx_to_cause(input int idx);
        return idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// ============================================================================
// Module   : intr_prio_enc
// Purpose  : Combinational fixed-priority encoder, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any_valid,
    output logic [CAUSE_W-1:0] cause
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any_valid = 1'b0;
        cause     = CAUSE_W'(CAUSE_NONE);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_valid = 1'b1;
                cause     = CAUSE_W'(idx_to_cause(i));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// Module   : intr_ctrl
// Purpose  : Parametrised interrupt controller: latch, mask, prioritise and
//            hand one request to the datapath with an ack/complete handshake.
//            Define INTR_SYNC_EN to add a 2-flop synchroniser on every source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               global_en,
    input  logic               irq_ack,
    input  logic               irq_complete,
    output logic               irq_valid,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    generate
        if ((NUM_SRC < 1) || (NUM_SRC > (2 ** CAUSE_W) - 1)) begin : g_bad_param
            $error("intr_ctrl: NUM_SRC must be 1..2**CAUSE_W-1");
        end
    endgenerate

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_eligible;
    logic               w_enc_valid;
    logic [CAUSE_W-1:0] w_enc_cause;
    logic               w_win_elig;
    logic               w_ack_take;
    intr_state_e        r_state;
    intr_state_e        w_state_nxt;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_cause_nxt;

`ifdef INTR_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src;
`endif

    assign w_rise     = w_src & ~r_src_q;
    assign w_eligible = r_pending & src_en & {NUM_SRC{global_en}};
    assign w_ack_take = (r_state == REQ) && irq_ack;

    // Edge sources: a new rise beats the ack-clear of the same bit.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_mode[i]) begin
                if (w_rise[i]) begin
                    w_pending_nxt[i] = 1'b1;
                end else if (w_ack_take && (r_cause == CAUSE_W'(idx_to_cause(i)))) begin
                    w_pending_nxt[i] = 1'b0;
                end
            end else begin
                w_pending_nxt[i] = w_src[i];
            end
        end
    end

    always_comb begin
        w_win_elig = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_cause == CAUSE_W'(idx_to_cause(i))) begin
                w_win_elig = w_eligible[i];
            end
        end
    end

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio_enc (
        .req       (w_eligible),
        .any_valid (w_enc_valid),
        .cause     (w_enc_cause)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            IDLE: begin
                if (w_enc_valid) begin
                    w_state_nxt = REQ;
                    w_cause_nxt = w_enc_cause;
                end
            end
            REQ: begin
                // Ack takes priority over withdrawal; cause is frozen otherwise.
                if (irq_ack) begin
                    w_state_nxt = SERVICE;
                    w_cause_nxt = CAUSE_W'(CAUSE_NONE);
                end else if (!global_en || !w_win_elig) begin
                    w_state_nxt = IDLE;
                    w_cause_nxt = CAUSE_W'(CAUSE_NONE);
                end
            end
            SERVICE: begin
                if (irq_complete) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cause_nxt = CAUSE_W'(CAUSE_NONE);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_q   <= '0;
            r_pending <= '0;
            r_state   <= IDLE;
            r_cause   <= CAUSE_W'(CAUSE_NONE);
        end else begin
            r_src_q   <= w_src;
            r_pending <= w_pending_nxt;
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    assign irq_valid  = (r_state == REQ);
    assign in_service = (r_state == SERVICE);
    assign irq_cause  = r_cause;
    assign pending    = r_pending;

endmodule

`default_nettype wire
